// File: rtl/ray_id_alloc_pkg.sv
// ============================================================================
// ray_id_alloc_pkg : shared ray-tracer types for the ray-ID allocator
// Rev 1.0
// ============================================================================
`default_nettype none

package ray_id_alloc_pkg;

    localparam int NUM_RAYS_DEF = 64;
    localparam int RAY_ID_W     = $clog2(NUM_RAYS_DEF);
    localparam int COORD_W      = 16;
    localparam int PIXEL_W      = 20;

    typedef logic [PIXEL_W-1:0]  pixelID_t;
    typedef logic [RAY_ID_W-1:0] rayID_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } vector_t;

    typedef struct packed {
        pixelID_t pixelID;
        vector_t  origin;
        vector_t  dir;
    } prg_ray_t;

    typedef struct packed {
        rayID_t  rayID;
        vector_t origin;
        vector_t dir;
    } tagged_ray_t;

    function automatic tagged_ray_t tag_ray(input rayID_t id, input prg_ray_t r);
        tagged_ray_t t;
        t.rayID  = id;
        t.origin = r.origin;
        t.dir    = r.dir;
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ray_id_alloc_id_free_fifo.sv
// ============================================================================
// id_free_fifo : circular free list of ray IDs with power-up fill and
//                sticky over-free detection
// Rev 1.0
// ============================================================================
`default_nettype none

module id_free_fifo
    import ray_id_alloc_pkg::*;
#(
    parameter int NUM_RAYS = NUM_RAYS_DEF,
    parameter int ID_W     = $clog2(NUM_RAYS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_pop,
    output logic [ID_W-1:0] o_head_id,
    input  logic            i_push,
    input  logic [ID_W-1:0] i_push_id,
    output logic [ID_W:0]   o_count,
    output logic            o_run,
    output logic            o_overfree
);

    localparam logic [0:0]    S_INIT   = 1'b0;
    localparam logic [0:0]    S_RUN    = 1'b1;
    localparam logic [ID_W:0] C_FULL   = (ID_W+1)'(NUM_RAYS);
    localparam logic [ID_W-1:0] C_LAST = ID_W'(NUM_RAYS - 1);

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_init_cnt;
    logic [ID_W-1:0] r_head;
    logic [ID_W-1:0] r_tail;
    logic [ID_W:0]   r_count;
    logic            r_overfree;
    logic [ID_W-1:0] r_list [NUM_RAYS];

    logic w_run;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_run     = (r_state == S_RUN);
    assign w_full    = (r_count == C_FULL);
    assign w_push_ok = w_run && i_push && !w_full;
    assign w_pop_ok  = w_run && i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overfree <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == C_LAST) begin
                        r_state <= S_RUN;
                        r_head  <= '0;
                        r_tail  <= '0;
                        r_count <= C_FULL;
                    end
                end
                default: begin
                    if (w_pop_ok)
                        r_head <= r_head + 1'b1;
                    if (w_push_ok)
                        r_tail <= r_tail + 1'b1;
                    // Simultaneous push and pop leave the occupancy unchanged
                    case ({w_push_ok, w_pop_ok})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                    if (i_push && w_full)
                        r_overfree <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == S_INIT)
                r_list[r_init_cnt] <= r_init_cnt;
            else if (w_push_ok)
                r_list[r_tail] <= i_push_id;
        end
    end

    assign o_head_id  = r_list[r_head];
    assign o_count    = r_count;
    assign o_run      = w_run;
    assign o_overfree = r_overfree;

endmodule

`default_nettype wire

// File: rtl/ray_id_alloc.sv
// ============================================================================
// ray_id_alloc : tags primary rays with free ray IDs, records their pixel,
//                and reports the pixel when an ID is retired
// Rev 1.0
// ============================================================================
`default_nettype none

module ray_id_alloc
    import ray_id_alloc_pkg::*;
#(
    parameter int NUM_RAYS = NUM_RAYS_DEF,
    parameter int ID_W     = $clog2(NUM_RAYS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prg_to_shader_valid,
    input  prg_ray_t        prg_to_shader_data,
    output logic            prg_to_shader_stall,
    output logic            ray_out_valid,
    output tagged_ray_t     ray_out_data,
    input  logic            ray_out_stall,
    input  logic            free_valid,
    input  logic [ID_W-1:0] free_rayID,
    output logic            pix_valid,
    output pixelID_t        pix_pixelID,
    output logic [ID_W:0]   free_count,
    output logic            err_overfree
);

    logic [ID_W-1:0] w_head_id;
    logic [ID_W:0]   w_count;
    logic            w_run;
    logic            w_stall;
    logic            w_accept;
    logic            w_free;

    logic            r_out_valid;
    tagged_ray_t     r_out_data;
    logic            r_pix_valid;
    pixelID_t        r_pix_id;
    pixelID_t        r_pix_table [NUM_RAYS];

    // Stall is built from registered occupancy only, so a freed ID is usable next cycle
    assign w_stall  = !w_run || (w_count == '0) || (r_out_valid && ray_out_stall);
    assign w_accept = prg_to_shader_valid && !w_stall;
    assign w_free   = w_run && free_valid;

    id_free_fifo #(
        .NUM_RAYS (NUM_RAYS),
        .ID_W     (ID_W)
    ) u_free_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_pop      (w_accept),
        .o_head_id  (w_head_id),
        .i_push     (w_free),
        .i_push_id  (free_rayID),
        .o_count    (w_count),
        .o_run      (w_run),
        .o_overfree (err_overfree)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= tag_ray(rayID_t'(w_head_id), prg_to_shader_data);
        end else if (!ray_out_stall) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_accept)
            r_pix_table[w_head_id] <= prg_to_shader_data.pixelID;
    end

    // The owner is reported even when the free itself is dropped as an over-free
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pix_valid <= 1'b0;
            r_pix_id    <= '0;
        end else begin
            r_pix_valid <= w_free;
            if (w_free)
                r_pix_id <= r_pix_table[free_rayID];
        end
    end

    assign prg_to_shader_stall = w_stall;
    assign ray_out_valid       = r_out_valid;
    assign ray_out_data        = r_out_data;
    assign pix_valid           = r_pix_valid;
    assign pix_pixelID         = r_pix_id;
    assign free_count          = w_count;

endmodule

`default_nettype wire
